// File: rtl/gpu_pkg.sv
// Shared constants and types for the GPU CPU-bus bridge: register map, FSM states and
// memory-region geometry.
package gpu_pkg;

  localparam logic [2:0] RegStatus = 3'd0;
  localparam logic [2:0] RegIncr   = 3'd3;
  localparam logic [2:0] RegAddrLo = 3'd4;
  localparam logic [2:0] RegAddrHi = 3'd5;
  localparam logic [2:0] RegData   = 3'd6;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StAdv,
    StFetch,
    StCap
  } bridge_state_e;

  // Bit positions inside the region one-hot.
  localparam int unsigned RegionTile  = 0;
  localparam int unsigned RegionAttr  = 1;
  localparam int unsigned RegionColor = 2;

  localparam int unsigned DefTileDepth  = 2048;
  localparam int unsigned DefAttrDepth  = 4096;
  localparam int unsigned DefColorDepth = 16;

  function automatic int unsigned region_limit(int unsigned tile_depth,
                                               int unsigned attr_depth,
                                               int unsigned color_depth);
    return tile_depth + attr_depth + color_depth;
  endfunction

  localparam int unsigned DefAttrBase  = DefTileDepth;
  localparam int unsigned DefColorBase = DefTileDepth + DefAttrDepth;
  localparam int unsigned DefLimit     = region_limit(DefTileDepth, DefAttrDepth, DefColorDepth);

endpackage

// File: rtl/gpu_region_decode.sv
// Maps the flat VRAM pointer onto tile/attr/colour regions. Offsets of unselected regions
// are held at zero so idle memory address buses stay quiet.
module gpu_region_decode import gpu_pkg::*; #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned TILE_DEPTH  = DefTileDepth,
  parameter int unsigned ATTR_DEPTH  = DefAttrDepth,
  parameter int unsigned COLOR_DEPTH = DefColorDepth
) (
  input  logic [ADDR_W-1:0]               ptr,
  output logic [2:0]                      region,
  output logic                            out_of_range,
  output logic [$clog2(TILE_DEPTH)-1:0]   tile_off,
  output logic [$clog2(ATTR_DEPTH)-1:0]   attr_off,
  output logic [$clog2(COLOR_DEPTH)-1:0]  color_off
);

  localparam int unsigned TileAw    = $clog2(TILE_DEPTH);
  localparam int unsigned AttrAw    = $clog2(ATTR_DEPTH);
  localparam int unsigned ColorAw   = $clog2(COLOR_DEPTH);
  localparam int unsigned AttrBase  = TILE_DEPTH;
  localparam int unsigned ColorBase = TILE_DEPTH + ATTR_DEPTH;
  localparam int unsigned Limit     = region_limit(TILE_DEPTH, ATTR_DEPTH, COLOR_DEPTH);

  logic [31:0] p;
  assign p = 32'(ptr);

  always_comb begin
    region       = '0;
    out_of_range = 1'b0;
    tile_off     = '0;
    attr_off     = '0;
    color_off    = '0;
    if (p < AttrBase) begin
      region[RegionTile] = 1'b1;
      tile_off           = TileAw'(p);
    end else if (p < ColorBase) begin
      region[RegionAttr] = 1'b1;
      attr_off           = AttrAw'(p - AttrBase);
    end else if (p < Limit) begin
      region[RegionColor] = 1'b1;
      color_off           = ColorAw'(p - ColorBase);
    end else begin
      out_of_range = 1'b1;
    end
  end

endmodule

// File: rtl/gpu_bus_bridge.sv
// CPU-facing register port of the GPU: windowed, auto-incrementing access to tile, attribute
// and colour RAM, with read-back through a one-byte prefetch buffer.
module gpu_bus_bridge import gpu_pkg::*; #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned TILE_DEPTH  = DefTileDepth,
  parameter int unsigned ATTR_DEPTH  = DefAttrDepth,
  parameter int unsigned COLOR_DEPTH = DefColorDepth
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cpu_cs_n,
  input  logic                            cpu_rw,
  input  logic [2:0]                      cpu_addr,
  input  logic [7:0]                      cpu_wdata,
  output logic [7:0]                      cpu_rdata,
  output logic                            cpu_rdata_oe,
  output logic                            tile_we,
  output logic                            tile_re,
  output logic [$clog2(TILE_DEPTH)-1:0]   tile_addr,
  output logic [7:0]                      tile_wdata,
  input  logic [7:0]                      tile_rdata,
  output logic                            attr_we,
  output logic                            attr_re,
  output logic [$clog2(ATTR_DEPTH)-1:0]   attr_addr,
  output logic [7:0]                      attr_wdata,
  input  logic [7:0]                      attr_rdata,
  output logic                            color_we,
  output logic                            color_re,
  output logic [$clog2(COLOR_DEPTH)-1:0]  color_addr,
  output logic [7:0]                      color_wdata,
  input  logic [7:0]                      color_rdata
);

  bridge_state_e     state_q, state_d;
  logic              cs_s1_q, cs_s2_q, cs_s3_q;
  logic              strobe;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        incr_q, incr_d;
  logic [7:0]        buf_q, buf_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              sticky_q, sticky_d;
  logic [2:0]        rd_sel_q;
  logic [15:0]       ptr_ext;
  logic              busy;
  logic [2:0]        region;
  logic              oor;
  logic [7:0]        rd_val;
  logic              rd_active;

  gpu_region_decode #(
    .ADDR_W      (ADDR_W),
    .TILE_DEPTH  (TILE_DEPTH),
    .ATTR_DEPTH  (ATTR_DEPTH),
    .COLOR_DEPTH (COLOR_DEPTH)
  ) u_decode (
    .ptr          (ptr_q),
    .region       (region),
    .out_of_range (oor),
    .tile_off     (tile_addr),
    .attr_off     (attr_addr),
    .color_off    (color_addr)
  );

  // Synchroniser resets high so no falling edge appears on the cycle after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cs_s1_q  <= 1'b1;
      cs_s2_q  <= 1'b1;
      cs_s3_q  <= 1'b1;
      rd_sel_q <= '0;
    end else begin
      cs_s1_q  <= cpu_cs_n;
      cs_s2_q  <= cs_s1_q;
      cs_s3_q  <= cs_s2_q;
      rd_sel_q <= cpu_addr;
    end
  end

  assign strobe  = cs_s3_q & ~cs_s2_q;
  assign busy    = (state_q != StIdle);
  assign ptr_ext = 16'(ptr_q);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (strobe) begin
          if (!cpu_rw) begin
            if (cpu_addr == RegData) begin
              state_d = StWr;
            end else if ((cpu_addr == RegAddrLo) || (cpu_addr == RegAddrHi)) begin
              state_d = StFetch;
            end
          end else if (cpu_addr == RegData) begin
            state_d = StAdv;
          end
        end
      end
      StWr:    state_d = StAdv;
      StAdv:   state_d = StFetch;
      StFetch: state_d = StCap;
      StCap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: memory strobes follow the decoded region, none when out of range.
  always_comb begin
    tile_we  = 1'b0;
    attr_we  = 1'b0;
    color_we = 1'b0;
    tile_re  = 1'b0;
    attr_re  = 1'b0;
    color_re = 1'b0;
    unique case (state_q)
      StWr: begin
        tile_we  = region[RegionTile];
        attr_we  = region[RegionAttr];
        color_we = region[RegionColor];
      end
      StFetch: begin
        tile_re  = region[RegionTile];
        attr_re  = region[RegionAttr];
        color_re = region[RegionColor];
      end
      default: ;
    endcase
  end

  always_comb begin
    ptr_d    = ptr_q;
    incr_d   = incr_q;
    buf_d    = buf_q;
    wdata_d  = wdata_q;
    sticky_d = sticky_q;
    if (strobe) begin
      if (busy) begin
        sticky_d = 1'b1;
      end else begin
        wdata_d = cpu_wdata;
        if (!cpu_rw) begin
          case (cpu_addr)
            RegIncr:   incr_d = cpu_wdata;
            RegAddrLo: ptr_d  = ADDR_W'({ptr_ext[15:8], cpu_wdata});
            RegAddrHi: ptr_d  = ADDR_W'({cpu_wdata, ptr_ext[7:0]});
            default: ;
          endcase
        end else if (cpu_addr == RegStatus) begin
          sticky_d = 1'b0;
        end
      end
    end
    case (state_q)
      StWr:  if (oor) sticky_d = 1'b1;
      StAdv: ptr_d = ptr_q + ADDR_W'(incr_q);
      // region is all-zero when out of range, so the buffer loads 0x00 there.
      StCap: buf_d = ({8{region[RegionTile]}}  & tile_rdata) |
                     ({8{region[RegionAttr]}}  & attr_rdata) |
                     ({8{region[RegionColor]}} & color_rdata);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q    <= '0;
      incr_q   <= 8'd1;
      buf_q    <= '0;
      wdata_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      incr_q   <= incr_d;
      buf_q    <= buf_d;
      wdata_q  <= wdata_d;
      sticky_q <= sticky_d;
    end
  end

  assign tile_wdata  = wdata_q;
  assign attr_wdata  = wdata_q;
  assign color_wdata = wdata_q;

  always_comb begin
    rd_val = '0;
    case (rd_sel_q)
      RegStatus: rd_val = {6'b0, sticky_q, busy};
      RegIncr:   rd_val = incr_q;
      RegAddrLo: rd_val = ptr_ext[7:0];
      RegAddrHi: rd_val = ptr_ext[15:8];
      RegData:   rd_val = buf_q;
      default:   rd_val = '0;
    endcase
  end

  assign rd_active    = rst & ~cpu_cs_n & cpu_rw;
  assign cpu_rdata_oe = rd_active;
  assign cpu_rdata    = rd_active ? rd_val : 8'h00;

endmodule
